// File: rtl/gt_serial_cmp.sv
// Multi-cycle unsigned magnitude comparator: scans operands two bits per cycle, MSB pair first,
// and stops at the first differing pair, leaving a registered gt/eq/lt verdict.
module gt_serial_cmp #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ready_o,
  output logic         done_o,
  output logic         a_gt_b_o,
  output logic         a_eq_b_o,
  output logic         a_lt_b_o
);

  localparam int unsigned S  = W / 2;
  localparam int unsigned CW = $clog2(S + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmp  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;

  logic [1:0] top_a, top_b;
  logic       slice_gt, slice_lt;

  // Shared 2-bit greater-than slice; lt is the same function with operands swapped.
  function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
    return (x[1] & ~y[1]) | (x[1] & y[1] & x[0] & ~y[0]) | (~x[1] & ~y[1] & x[0] & ~y[0]);
  endfunction

  assign top_a    = sa_q[W-1 -: 2];
  assign top_b    = sb_q[W-1 -: 2];
  assign slice_gt = gt2(top_a, top_b);
  assign slice_lt = gt2(top_b, top_a);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          cnt_d   = CW'(S);
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (slice_gt) begin
          gt_d    = 1'b1;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StDone;
        end else if (slice_lt) begin
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b1;
          state_d = StDone;
        end else if (cnt_q == CW'(1)) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = StDone;
        end else begin
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign done_o   = (state_q == StDone);
  assign a_gt_b_o = gt_q;
  assign a_eq_b_o = eq_q;
  assign a_lt_b_o = lt_q;

endmodule

// File: tb/tb_gt_serial_cmp.sv
// Scoreboard bench for gt_serial_cmp: W=8 and W=2 instances, directed vectors with
// hand-computed verdicts and done-cycle expectations checked by per-instance monitors.
module tb_gt_serial_cmp;

  typedef struct {
    logic [2:0] res;  // {gt, eq, lt}
    int         cyc;
  } exp_t;

  localparam logic [2:0] RGt = 3'b100;
  localparam logic [2:0] REq = 3'b010;
  localparam logic [2:0] RLt = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready8, done8, gt8, eq8, lt8;
  logic       ready2, done2, gt2, eq2, lt2;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q8[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gt_serial_cmp #(.W(8)) u_dut8 (
    .clk_i(clk), .reset_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
    .ready_o(ready8), .done_o(done8), .a_gt_b_o(gt8), .a_eq_b_o(eq8), .a_lt_b_o(lt8)
  );

  gt_serial_cmp #(.W(2)) u_dut2 (
    .clk_i(clk), .reset_i(rst), .start_i(start2), .a_i(a2), .b_i(b2),
    .ready_o(ready2), .done_o(done2), .a_gt_b_o(gt2), .a_eq_b_o(eq2), .a_lt_b_o(lt2)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      chk("w8_done_expected", int'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("w8_result", int'({gt8, eq8, lt8}), int'(e.res));
        chk("w8_done_cycle", cyc, e.cyc);
        chk("w8_ready_low_in_done", int'(ready8), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2 === 1'b1) begin
      chk("w2_done_expected", int'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("w2_result", int'({gt2, eq2, lt2}), int'(e.res));
        chk("w2_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge where ready is back high.
  task automatic issue(input bit w2, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] er, input int k);
    int   c0;
    int   n;
    exp_t e;
    n = 0;
    while (!(w2 ? ready2 : ready8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(w2 ? "w2_ready_before_start" : "w8_ready_before_start",
        int'(w2 ? ready2 : ready8), 1);
    c0 = cyc;
    if (w2) begin
      a2 = av[1:0]; b2 = bv[1:0]; start2 = 1'b1;
    end else begin
      a8 = av; b8 = bv; start8 = 1'b1;
    end
    e.res = er;
    e.cyc = c0 + 1 + k;
    if (w2) q2.push_back(e);
    else q8.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    start8 = 1'b0;
    n = 0;
    while (!(w2 ? ready2 : ready8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(w2 ? "w2_ready_return_cycle" : "w8_ready_return_cycle", cyc, c0 + k + 2);
  endtask

  initial begin
    int   c0;
    int   n;
    exp_t e;
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   n;
    exp_t e;
    logic [2:0] er;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("w8_reset_ready", int'(ready8), 1);
    chk("w8_reset_done", int'(done8), 0);
    chk("w8_reset_results", int'({gt8, eq8, lt8}), 0);
    chk("w2_reset_ready", int'(ready2), 1);
    chk("w2_reset_results", int'({gt2, eq2, lt2}), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 8'hA5, 8'h5A, RGt, 1);
    issue(1'b0, 8'h3C, 8'h3D, RLt, 4);
    issue(1'b0, 8'hFF, 8'hFF, REq, 4);
    issue(1'b0, 8'h00, 8'h00, REq, 4);
    issue(1'b0, 8'h40, 8'h80, RLt, 1);
    issue(1'b0, 8'h90, 8'h80, RGt, 2);
    issue(1'b0, 8'h24, 8'h28, RLt, 3);
    issue(1'b0, 8'h0B, 8'h09, RGt, 4);

    // start held high while operands churn during CMP/DONE.
    c0 = cyc;
    a8 = 8'h12; b8 = 8'h13; start8 = 1'b1;
    e.res = RLt;
    e.cyc = c0 + 1 + 4;
    q8.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ready8) begin
        a8 = 8'hF0 + 8'(n);
        b8 = 8'h0F;
      end
    end while (!ready8 && n < 50);
    start8 = 1'b0;
    chk("w8_hold_ready_return_cycle", cyc, c0 + 6);
    repeat (3) @(negedge clk);

    // Reset lands in the second CMP cycle; the compare must vanish without a done.
    c0 = cyc;
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("w8_midreset_ready", int'(ready8), 1);
    chk("w8_midreset_results", int'({gt8, eq8, lt8}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("w8_postreset_ready", int'(ready8), 1);
    chk("w8_postreset_done", int'(done8), 0);
    repeat (5) @(negedge clk);
    chk("w8_postreset_results_held", int'({gt8, eq8, lt8}), 0);
    issue(1'b0, 8'h01, 8'h02, RLt, 4);

    issue(1'b1, 8'h03, 8'h02, RGt, 1);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        er = (i > j) ? RGt : ((i == j) ? REq : RLt);
        issue(1'b1, 8'(i), 8'(j), er, 1);
      end
    end
    chk("w2_results_held_idle", int'({gt2, eq2, lt2}), int'(REq));

    n = 0;
    while ((q8.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w8_pending_at_end", q8.size(), 0);
    chk("w2_pending_at_end", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gt_serial_cmp.md
# gt_serial_cmp

Multi-cycle magnitude comparator for W-bit unsigned operands. It scans the operands two bits at a time, most-significant pair first, using the same 2-bit greater-than function the team already has as the per-slice compare. It terminates early at the first differing pair. It sits upstream of control logic that needs a registered gt/eq/lt verdict on wide operands without a wide combinational compare.

## Interface

Parameters:
- W, default 8: operand width; must be even and ≥ 2. Slice count S = W/2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when ready=1.
- a  input  W  operand A, unsigned; sampled on the accepted start edge only.
- b  input  W  operand B, unsigned; sampled on the accepted start edge only.
- ready  output  1  block idle and able to accept start.
- done  output  1  one-cycle pulse; result outputs valid and updated this cycle.
- a_gt_b  output  1  registered result, A > B.
- a_eq_b  output  1  registered result, A == B.
- a_lt_b  output  1  registered result, A < B.

## Operation

- States: IDLE, CMP, DONE. Reset state is IDLE.
- Reset values: ready=1, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0; shift registers and slice counter cleared.
- IDLE: ready=1. When start=1:
  - Load a and b into shift registers sa and sb.
  - Load the slice counter with S.
  - Go to CMP.
- IDLE with start=0: remain in IDLE.
- CMP: each cycle, compare the top pairs sa[W-1:W-2] and sb[W-1:W-2].
  - Slice gt = (a1·~b1) + (a1·b1·a0·~b0) + (~a1·~b1·a0·~b0).
  - Slice lt = the same function with operands swapped.
  - gt=1: capture gt result (a_gt_b=1, others 0), go to DONE.
  - lt=1: capture lt result (a_lt_b=1, others 0), go to DONE.
  - Pairs equal and counter==1: capture eq result (a_eq_b=1, others 0), go to DONE.
  - Pairs equal and counter>1: shift sa and sb left by 2 (zero fill), decrement the counter, stay in CMP.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Result outputs:
  - Exactly one of gt/eq/lt is 1 after the first completed compare; all three are 0 only before the first completed compare.
  - Results hold their value through subsequent IDLE and CMP cycles.
  - Results change only on the edge that enters DONE.
- start is ignored while ready=0 (CMP or DONE); a and b changing during CMP have no effect.
- reset asserted in any state, including mid-CMP: next cycle is IDLE with all reset values. The in-flight compare is discarded and no done pulse is issued.

## Timing

- Accepted start at edge t0. Let k = index (1..S) of the first differing slice counted from the MSB; k = S if the operands are equal.
- CMP occupies cycles t0+1 … t0+k.
- done=1 and results valid in cycle t0+k+1.
- ready=0 from cycle t0+1 through t0+k+1; ready=1 from cycle t0+k+2.
- Latency from start to done: k+1 cycles. Minimum 2 (MSB pair differs), maximum S+1 (equal, or difference only in the LSB pair).
- Throughput: a new start may be accepted in cycle t0+k+2 at the earliest, so back-to-back compares are spaced k+2 cycles apart.
- W=2 degenerate case: S=1; every compare takes exactly 2 cycles start→done.

## Test plan

- W=8, a=0xA5, b=0x5A: MSB pair 10 vs 01 → done in cycle t0+2, a_gt_b=1, a_eq_b=0, a_lt_b=0.
- W=8, a=0x3C, b=0x3D: first difference at slice 4 (00 vs 01) → done at t0+5, a_lt_b=1; ready returns high at t0+6.
- W=8, a=b=0xFF: → done at t0+5, a_eq_b=1. Then a=0x00, b=0x00 started at t0+6 → done at t0+11, eq still 1. Confirm exactly one done pulse per compare.
- Start held high continuously with operands changing every cycle during CMP: only the first start is accepted; result reflects the original operands; no extra done pulses.
- Reset asserted in cycle t0+2 of an 8-bit compare (a=0x01, b=0x02): no done pulse, all results 0, ready=1 in the cycle after reset deasserts. A fresh start then completes normally.
- W=2, a=2'b11, b=2'b10: done at t0+2, a_gt_b=1. Exhaustive 16-pair sweep matches a>b, a==b, a<b.
